// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU.
//  alu_op_e    : 4-bit operation code produced by the ALU control decoder
//  alu_state_e : sequencing states of the execute unit (IDLE / SHIFT)
//  is_shift    : true for SLL, SRL and SRA
//  is_illegal  : true for the two unassigned codes 4'b1110 / 4'b1111
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_ADD  = 4'b0011,
    ALU_BNE  = 4'b0100,
    ALU_BLT  = 4'b0101,
    ALU_BGE  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_BEQ  = 4'b1000,
    ALU_SUB  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_SLL  = 4'b1100,
    ALU_JAL  = 4'b1101,
    ALU_ILL0 = 4'b1110,
    ALU_ILL1 = 4'b1111
  } alu_op_e;

  typedef enum logic {
    ALU_IDLE  = 1'b0,
    ALU_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_illegal(alu_op_e op);
    return (op == ALU_ILL0) || (op == ALU_ILL1);
  endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// alu_serial_shifter: bit-serial shifter used by alu_exec_unit.
//  Shifts one bit per clock; holds the remaining-count register and the
//  working value.
// Ports:
//  clk     in   clock, rising edge
//  rst_n   in   synchronous active-low reset (clears counter and working value)
//  start   in   load value/op/shamt; shamt must be non-zero
//  op      in   ALU_SLL / ALU_SRL / ALU_SRA
//  value   in   operand to shift
//  shamt   in   shift amount (1 .. DATA_WIDTH-1)
//  done    out  final bit is being shifted this cycle; result valid now
//  result  out  shifted value (combinational, meaningful when done=1)
import alu_pkg::*;

module alu_serial_shifter #(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned SHAMT_W   = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [SHAMT_W-1:0]    shamt,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  logic [SHAMT_W-1:0]    cnt;
  logic [DATA_WIDTH-1:0] work;
  alu_op_e               op_q;
  logic [DATA_WIDTH-1:0] step;

  // SRA replicates the current MSB, which is the original MSB because an
  // arithmetic right shift never changes it.
  always_comb begin
    step = {1'b0, work[DATA_WIDTH-1:1]};
    case (op_q)
      ALU_SLL: step = {work[DATA_WIDTH-2:0], 1'b0};
      ALU_SRA: step = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
      default: step = {1'b0, work[DATA_WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      work <= '0;
      op_q <= ALU_SRL;
    end else if (start) begin
      cnt  <= shamt;
      work <= value;
      op_q <= op;
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      work <= step;
    end
  end

  assign done   = (cnt == SHAMT_W'(1));
  assign result = step;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
//  Non-shift ops complete in one cycle. Shifts are bit-serial (shamt+1 cycles)
//  unless the macro ALU_BARREL_SHIFT_EN is defined, in which case a
//  combinational barrel shifter gives 1-cycle latency and no SHIFT state or
//  counter is built. Results are identical in both builds.
// Ports:
//  clk          in   clock, rising edge
//  rst_n        in   synchronous active-low reset
//  in_valid     in   operation offered
//  in_ready     out  operation accepted this cycle when in_valid=1
//  in_op        in   4-bit operation code (alu_pkg::alu_op_e)
//  in_a         in   operand A
//  in_b         in   operand B; shift amount is in_b[SHAMT_W-1:0]
//  out_valid    out  result held
//  out_ready    in   consumer takes the result this cycle
//  out_result   out  result
//  out_zero     out  out_result == 0
//  out_illegal  out  op code was 4'b1110 or 4'b1111
import alu_pkg::*;

module alu_exec_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_illegal
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  alu_op_e               op;
  logic [SHAMT_W-1:0]    shamt;
  logic                  out_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] comb_res;
  logic                  comb_ill;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_res;
  logic                  load_ill;

  assign op       = alu_op_e'(in_op);
  assign shamt    = in_b[SHAMT_W-1:0];
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Single-cycle result for everything the unit can finish on accept.
  always_comb begin
    comb_res = '0;
    comb_ill = 1'b0;
    case (op)
      ALU_AND:          comb_res = in_a & in_b;
      ALU_OR:           comb_res = in_a | in_b;
      ALU_XOR:          comb_res = in_a ^ in_b;
      ALU_ADD:          comb_res = in_a + in_b;
      ALU_SUB:          comb_res = in_a - in_b;
      ALU_SLT, ALU_BLT: comb_res = DATA_WIDTH'($signed(in_a) < $signed(in_b));
      ALU_BGE:          comb_res = DATA_WIDTH'($signed(in_a) >= $signed(in_b));
      ALU_BEQ:          comb_res = DATA_WIDTH'(in_a == in_b);
      ALU_BNE:          comb_res = DATA_WIDTH'(in_a != in_b);
      ALU_JAL:          comb_res = DATA_WIDTH'(1'b1);
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:          comb_res = in_a << shamt;
      ALU_SRL:          comb_res = in_a >> shamt;
      ALU_SRA:          comb_res = $unsigned($signed(in_a) >>> shamt);
`else
      // Only reached with shamt==0; non-zero amounts go through the serial path.
      ALU_SLL, ALU_SRL, ALU_SRA: comb_res = in_a;
`endif
      ALU_ILL0, ALU_ILL1: begin
        comb_res = '0;
        comb_ill = 1'b1;
      end
      default:          comb_res = '0;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  alu_state_e            state;
  alu_state_e            state_next;
  logic                  sh_start;
  logic                  sh_done;
  logic [DATA_WIDTH-1:0] sh_result;

  alu_serial_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (sh_start),
    .op     (op),
    .value  (in_a),
    .shamt  (shamt),
    .done   (sh_done),
    .result (sh_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ALU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign in_ready = rst_n && (state == ALU_IDLE) && out_free;

  // Entering SHIFT requires a free or draining output, and nothing can be
  // loaded while shifting, so the output is always empty at completion.
  always_comb begin
    state_next = state;
    sh_start   = 1'b0;
    load       = 1'b0;
    load_res   = comb_res;
    load_ill   = comb_ill;
    case (state)
      ALU_IDLE: begin
        if (accept) begin
          if (is_shift(op) && (shamt != '0)) begin
            sh_start   = 1'b1;
            state_next = ALU_SHIFT;
          end else begin
            load = 1'b1;
          end
        end
      end
      ALU_SHIFT: begin
        if (sh_done) begin
          load       = 1'b1;
          load_res   = sh_result;
          load_ill   = 1'b0;
          state_next = ALU_IDLE;
        end
      end
      default: state_next = ALU_IDLE;
    endcase
  end
`else
  assign in_ready = rst_n && out_free;

  always_comb begin
    load     = accept;
    load_res = comb_res;
    load_ill = comb_ill;
  end
`endif

  // A load in the same cycle as a drain keeps out_valid high (1/cycle throughput).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_result  <= load_res;
      out_zero    <= (load_res == '0);
      out_illegal <= load_ill;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
